// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control
// ----------------------------------------------------------------------------
// Multi-cycle LEGv8 control unit. Walks each instruction through
// FETCH / DECODE / EXEC / ADDR / MEM / WB / BRANCH and drives the datapath
// strobes for the current state. A sticky TRAP state captures illegal opcodes
// and memory handshake timeouts; it is left only through reset.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   opcode        in   instruction[31:21]; sampled in DECODE only
//   zero          in   ALU zero flag; used in BRANCH
//   mem_ready     in   memory completes the current request this cycle
//   stall         in   freeze request (holds state, zeroes controls)
//   pc_write      out  PC load strobe
//   ir_write      out  instruction register load strobe
//   reg2_loc      out  register-file read port 2 selects Rt
//   uncondbranch  out  unconditional branch
//   branch        out  conditional branch
//   mem_read      out  memory read request
//   mem_write     out  memory write request
//   mem_to_reg    out  write-back data comes from memory
//   alu_src       out  ALU operand B comes from the immediate
//   reg_write     out  register-file write enable
//   alu_op        out  00 add, 01 pass-B/compare, 10 funct decode
//   state         out  current state encoding (debug)
//   illegal       out  sticky trap: bad opcode
//   mem_timeout   out  sticky trap: memory handshake timeout
// ============================================================================
module multicycle_control #(
    parameter int OPCODE_WIDTH = 11,
    parameter int MEM_TIMEOUT  = 15,
    parameter bit ENABLE_IMM   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero,
    input  logic                    mem_ready,
    input  logic                    stall,
    output logic                    pc_write,
    output logic                    ir_write,
    output logic                    reg2_loc,
    output logic                    uncondbranch,
    output logic                    branch,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    mem_to_reg,
    output logic                    alu_src,
    output logic                    reg_write,
    output logic [1:0]              alu_op,
    output logic [2:0]              state,
    output logic                    illegal,
    output logic                    mem_timeout
);

    // ------------------------------------------------------------------------
    // Types
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_ADDR   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_BRANCH = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE,
        C_ITYPE,
        C_LDUR,
        C_STUR,
        C_CBZ,
        C_CBNZ,
        C_B,
        C_ILLEGAL
    } iclass_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASSB = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Wait counter is 8 bits wide, enough for the largest legal timeout (255).
    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    // ------------------------------------------------------------------------
    // Opcode classification
    // ------------------------------------------------------------------------
    // Ranged classes are matched on their fixed upper bits:
    //   ADDI 488-489 / SUBI 688-689 -> op[10:1]
    //   CBZ 5A0-5A7 / CBNZ 5A8-5AF  -> op[10:3]
    //   B 0A0-0BF                   -> op[10:5]
    function automatic iclass_t classify(input logic [10:0] op);
        iclass_t cls;
        cls = C_ILLEGAL;
        if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550) begin
            cls = C_RTYPE;
        end else if (ENABLE_IMM && (op[10:1] == 10'h244 || op[10:1] == 10'h344)) begin
            cls = C_ITYPE;
        end else if (op == 11'h7C2) begin
            cls = C_LDUR;
        end else if (op == 11'h7C0) begin
            cls = C_STUR;
        end else if (op[10:3] == 8'hB4) begin
            cls = C_CBZ;
        end else if (op[10:3] == 8'hB5) begin
            cls = C_CBNZ;
        end else if (op[10:5] == 6'h05) begin
            cls = C_B;
        end
        return cls;
    endfunction

    // ------------------------------------------------------------------------
    // Registers and decode wires
    // ------------------------------------------------------------------------
    state_t      r_state;
    logic [7:0]  r_wait_cnt;
    logic [10:0] r_opcode;
    logic        r_illegal;
    logic        r_mem_timeout;

    logic [10:0] w_opcode_live;
    iclass_t     w_cls_live;
    iclass_t     w_cls;
    logic        w_wait_expired;

    assign w_opcode_live  = opcode[OPCODE_WIDTH-1 -: 11];
    assign w_cls_live     = classify(w_opcode_live);
    assign w_cls          = classify(r_opcode);
    assign w_wait_expired = (r_wait_cnt == TIMEOUT_CNT);

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    // The counter is cleared on every entry to FETCH or MEM and advances once
    // per cycle spent waiting there. When it has reached TIMEOUT_CNT and
    // mem_ready is still low, the unit traps; a ready on that same cycle
    // completes normally. A stall freezes everything, which in TRAP is
    // indistinguishable from the normal hold.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_wait_cnt    <= 8'd0;
            r_opcode      <= 11'd0;
            r_illegal     <= 1'b0;
            r_mem_timeout <= 1'b0;
        end else if (!stall) begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_wait_expired) begin
                        r_state       <= S_TRAP;
                        r_mem_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end

                S_DECODE: begin
                    r_opcode <= w_opcode_live;
                    case (w_cls_live)
                        C_RTYPE, C_ITYPE:  r_state <= S_EXEC;
                        C_LDUR, C_STUR:    r_state <= S_ADDR;
                        C_CBZ, C_CBNZ, C_B: r_state <= S_BRANCH;
                        default: begin
                            r_state   <= S_TRAP;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end

                S_EXEC: begin
                    r_state <= S_WB;
                end

                S_ADDR: begin
                    r_state    <= S_MEM;
                    r_wait_cnt <= 8'd0;
                end

                S_MEM: begin
                    if (mem_ready) begin
                        if (w_cls == C_LDUR) begin
                            r_state <= S_WB;
                        end else begin
                            r_state    <= S_FETCH;
                            r_wait_cnt <= 8'd0;
                        end
                    end else if (w_wait_expired) begin
                        r_state       <= S_TRAP;
                        r_mem_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end

                S_WB, S_BRANCH: begin
                    r_state    <= S_FETCH;
                    r_wait_cnt <= 8'd0;
                end

                default: begin
                    // TRAP: held until reset.
                    r_state <= S_TRAP;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    // Strobes are decoded from the registered state and latched opcode, but
    // the FETCH handshake strobes follow mem_ready and the conditional-branch
    // PC load follows zero within the same cycle, so this stays combinational
    // rather than registered. Reset and stall both force every strobe low.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        reg2_loc     = 1'b0;
        uncondbranch = 1'b0;
        branch       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src      = 1'b0;
        reg_write    = 1'b0;
        alu_op       = ALU_ADD;

        if (!reset && !stall) begin
            case (r_state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        alu_op   = ALU_ADD;
                    end
                end

                S_EXEC: begin
                    alu_op  = ALU_FUNCT;
                    alu_src = (w_cls == C_ITYPE);
                end

                S_ADDR: begin
                    alu_src  = 1'b1;
                    alu_op   = ALU_ADD;
                    reg2_loc = (w_cls == C_STUR);
                end

                S_MEM: begin
                    if (w_cls == C_STUR) begin
                        mem_write = 1'b1;
                        reg2_loc  = 1'b1;
                    end else begin
                        mem_read = 1'b1;
                    end
                end

                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (w_cls == C_LDUR);
                end

                S_BRANCH: begin
                    if (w_cls == C_B) begin
                        uncondbranch = 1'b1;
                        pc_write     = 1'b1;
                    end else begin
                        reg2_loc = 1'b1;
                        branch   = 1'b1;
                        alu_op   = ALU_PASSB;
                        pc_write = (w_cls == C_CBNZ) ? ~zero : zero;
                    end
                end

                default: begin
                    // DECODE and TRAP drive no controls.
                end
            endcase
        end
    end

    assign state       = r_state;
    assign illegal     = r_illegal;
    assign mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control
// ----------------------------------------------------------------------------
// Directed bench for multicycle_control. The stimulus thread drives one cycle
// at a time and queues the hand-computed output vector for that cycle; an
// independent monitor pops the queue on every falling edge and compares.
// A second instance built with ENABLE_IMM=0 shares all inputs; only its
// illegal flag is tracked.
// ============================================================================
module tb_multicycle_control;

    // Control flag masks, packed in this order:
    // pc_write ir_write reg2_loc uncondbranch branch mem_read mem_write
    // mem_to_reg alu_src reg_write
    localparam logic [9:0] F_PCW = 10'b10_0000_0000;
    localparam logic [9:0] F_IRW = 10'b01_0000_0000;
    localparam logic [9:0] F_R2L = 10'b00_1000_0000;
    localparam logic [9:0] F_UBR = 10'b00_0100_0000;
    localparam logic [9:0] F_BR  = 10'b00_0010_0000;
    localparam logic [9:0] F_MRD = 10'b00_0001_0000;
    localparam logic [9:0] F_MWR = 10'b00_0000_1000;
    localparam logic [9:0] F_M2R = 10'b00_0000_0100;
    localparam logic [9:0] F_ASR = 10'b00_0000_0010;
    localparam logic [9:0] F_RWR = 10'b00_0000_0001;
    localparam logic [9:0] F_NONE = 10'b00_0000_0000;

    typedef struct packed {
        logic [9:0] flags;
        logic [1:0] alu_op;
        logic [2:0] state;
        logic       illegal;
        logic       mem_timeout;
        logic       ill2;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] opcode = 11'h3FF;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        stall = 1'b0;

    logic       pc_write, ir_write, reg2_loc, uncondbranch, branch;
    logic       mem_read, mem_write, mem_to_reg, alu_src, reg_write;
    logic [1:0] alu_op;
    logic [2:0] state;
    logic       illegal, mem_timeout;

    logic       d2_pc_write, d2_ir_write, d2_reg2_loc, d2_uncondbranch, d2_branch;
    logic       d2_mem_read, d2_mem_write, d2_mem_to_reg, d2_alu_src, d2_reg_write;
    logic [1:0] d2_alu_op;
    logic [2:0] d2_state;
    logic       d2_illegal, d2_mem_timeout;

    multicycle_control #(.OPCODE_WIDTH(11), .MEM_TIMEOUT(15), .ENABLE_IMM(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .stall(stall),
        .pc_write(pc_write), .ir_write(ir_write), .reg2_loc(reg2_loc),
        .uncondbranch(uncondbranch), .branch(branch), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
        .reg_write(reg_write), .alu_op(alu_op), .state(state),
        .illegal(illegal), .mem_timeout(mem_timeout)
    );

    multicycle_control #(.OPCODE_WIDTH(11), .MEM_TIMEOUT(15), .ENABLE_IMM(1'b0)) dut_noimm (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .stall(stall),
        .pc_write(d2_pc_write), .ir_write(d2_ir_write), .reg2_loc(d2_reg2_loc),
        .uncondbranch(d2_uncondbranch), .branch(d2_branch), .mem_read(d2_mem_read),
        .mem_write(d2_mem_write), .mem_to_reg(d2_mem_to_reg), .alu_src(d2_alu_src),
        .reg_write(d2_reg_write), .alu_op(d2_alu_op), .state(d2_state),
        .illegal(d2_illegal), .mem_timeout(d2_mem_timeout)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    obs_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Expected sticky flags, updated by the stimulus as traps are provoked.
    logic t_ill = 1'b0;
    logic t_to = 1'b0;
    logic t_ill2 = 1'b0;

    function automatic obs_t ex(input logic [2:0] st, input logic [9:0] f, input logic [1:0] op);
        obs_t o;
        o.flags       = f;
        o.alu_op      = op;
        o.state       = st;
        o.illegal     = t_ill;
        o.mem_timeout = t_to;
        o.ill2        = t_ill2;
        return o;
    endfunction

    task automatic check(input string nm, input obs_t got, input obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got flags=%b alu_op=%b state=%0d ill=%b to=%b ill2=%b, want flags=%b alu_op=%b state=%0d ill=%b to=%b ill2=%b",
                     nm, got.flags, got.alu_op, got.state, got.illegal, got.mem_timeout, got.ill2,
                     want.flags, want.alu_op, want.state, want.illegal, want.mem_timeout, want.ill2);
        end
    endtask

    always @(negedge clk) begin : monitor
        obs_t  got;
        obs_t  want;
        string nm;
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            got.flags = {pc_write, ir_write, reg2_loc, uncondbranch, branch,
                         mem_read, mem_write, mem_to_reg, alu_src, reg_write};
            got.alu_op      = alu_op;
            got.state       = state;
            got.illegal     = illegal;
            got.mem_timeout = mem_timeout;
            got.ill2        = d2_illegal;
            check(nm, got, want);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic step(input string nm, input logic rst, input logic rdy,
                        input logic z, input logic stl, input obs_t e);
        reset     = rst;
        mem_ready = rdy;
        zero      = z;
        stall     = stl;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string nm);
        step(nm, 1'b0, 1'b1, 1'b0, 1'b0, ex(3'd0, F_MRD | F_IRW | F_PCW, 2'b00));
    endtask

    // Opcode is only valid during DECODE; afterwards it is replaced with an
    // unrelated illegal pattern so latching is exercised.
    task automatic decode(input string nm, input logic [10:0] op);
        opcode = op;
        step(nm, 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd1, F_NONE, 2'b00));
        opcode = 11'h3FF;
    endtask

    task automatic do_reset(input string nm);
        t_ill  = 1'b0;
        t_to   = 1'b0;
        t_ill2 = 1'b0;
        step(nm, 1'b1, 1'b1, 1'b1, 1'b0, ex(3'd0, F_NONE, 2'b00));
        step(nm, 1'b1, 1'b1, 1'b0, 1'b1, ex(3'd0, F_NONE, 2'b00));
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin : stimulus
        @(posedge clk);
        #1;
        do_reset("reset_outputs_zero");

        // ADD: FETCH, DECODE, EXEC, WB
        fetch("add_fetch");
        decode("add_decode", 11'h458);
        step("add_exec", 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd2, F_NONE, 2'b10));
        step("add_wb", 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd5, F_RWR, 2'b00));

        // LDUR with three wait cycles in MEM
        fetch("ldur_fetch");
        decode("ldur_decode", 11'h7C2);
        step("ldur_addr", 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd3, F_ASR, 2'b00));
        for (int i = 0; i < 3; i++)
            step("ldur_mem_wait", 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd4, F_MRD, 2'b00));
        step("ldur_mem_done", 1'b0, 1'b1, 1'b0, 1'b0, ex(3'd4, F_MRD, 2'b00));
        step("ldur_wb", 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd5, F_RWR | F_M2R, 2'b00));

        // Conditional and unconditional branches
        fetch("cbnz_z0_fetch");
        decode("cbnz_z0_decode", 11'h5AA);
        step("cbnz_z0_branch", 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd6, F_R2L | F_BR | F_PCW, 2'b01));
        fetch("cbnz_z1_fetch");
        decode("cbnz_z1_decode", 11'h5AA);
        step("cbnz_z1_branch", 1'b0, 1'b0, 1'b1, 1'b0, ex(3'd6, F_R2L | F_BR, 2'b01));
        fetch("cbz_z1_fetch");
        decode("cbz_z1_decode", 11'h5A3);
        step("cbz_z1_branch", 1'b0, 1'b0, 1'b1, 1'b0, ex(3'd6, F_R2L | F_BR | F_PCW, 2'b01));
        fetch("cbz_z0_fetch");
        decode("cbz_z0_decode", 11'h5A7);
        step("cbz_z0_branch", 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd6, F_R2L | F_BR, 2'b01));
        fetch("b_fetch");
        decode("b_decode", 11'h0BF);
        step("b_branch", 1'b0, 1'b0, 1'b1, 1'b0, ex(3'd6, F_UBR | F_PCW, 2'b00));

        // Stall in FETCH ignores mem_ready, then STUR with stall in MEM
        step("fetch_stall", 1'b0, 1'b1, 1'b0, 1'b1, ex(3'd0, F_NONE, 2'b00));
        fetch("stur_fetch");
        decode("stur_decode", 11'h7C0);
        step("stur_addr", 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd3, F_ASR | F_R2L, 2'b00));
        step("stur_mem_stall", 1'b0, 1'b1, 1'b0, 1'b1, ex(3'd4, F_NONE, 2'b00));
        step("stur_mem_stall", 1'b0, 1'b1, 1'b0, 1'b1, ex(3'd4, F_NONE, 2'b00));
        step("stur_mem_write", 1'b0, 1'b1, 1'b0, 1'b0, ex(3'd4, F_MWR | F_R2L, 2'b00));
        fetch("after_stur_fetch");
        decode("subi_decode", 11'h689);
        t_ill2 = 1'b1;
        step("subi_exec", 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd2, F_ASR, 2'b10));
        step("subi_wb", 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd5, F_RWR, 2'b00));
        do_reset("reset_after_subi");

        // FETCH timeout: 15 counted waits, trap on the 16th low cycle
        for (int i = 0; i < 16; i++)
            step("fetch_to_wait", 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd0, F_MRD, 2'b00));
        t_to = 1'b1;
        step("fetch_to_trap", 1'b0, 1'b1, 1'b0, 1'b0, ex(3'd7, F_NONE, 2'b00));
        step("fetch_to_trap_stall", 1'b0, 1'b1, 1'b1, 1'b1, ex(3'd7, F_NONE, 2'b00));
        step("fetch_to_trap_hold", 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd7, F_NONE, 2'b00));
        do_reset("reset_clears_timeout");

        // Ready on the final allowed cycle wins over the timeout
        for (int i = 0; i < 15; i++)
            step("fetch_late_wait", 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd0, F_MRD, 2'b00));
        fetch("fetch_late_ready");
        decode("late_decode", 11'h550);
        step("orr_exec", 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd2, F_NONE, 2'b10));
        step("orr_wb", 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd5, F_RWR, 2'b00));

        // MEM timeout on a load
        fetch("memto_fetch");
        decode("memto_decode", 11'h7C2);
        step("memto_addr", 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd3, F_ASR, 2'b00));
        for (int i = 0; i < 16; i++)
            step("memto_wait", 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd4, F_MRD, 2'b00));
        t_to = 1'b1;
        step("memto_trap", 1'b0, 1'b1, 1'b0, 1'b0, ex(3'd7, F_NONE, 2'b00));
        do_reset("reset_after_memto");

        // Illegal opcode traps both instances and holds for 10 cycles
        fetch("ill_fetch");
        decode("ill_decode", 11'h765);
        t_ill  = 1'b1;
        t_ill2 = 1'b1;
        for (int i = 0; i < 10; i++)
            step("ill_trap_hold", 1'b0, 1'(i % 2), 1'(i % 3 == 0), 1'(i % 4 == 1),
                 ex(3'd7, F_NONE, 2'b00));
        do_reset("reset_clears_illegal");

        // ADDI: legal with immediates enabled, illegal on the second instance
        fetch("addi_fetch");
        decode("addi_decode", 11'h488);
        t_ill2 = 1'b1;
        step("addi_exec", 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd2, F_ASR, 2'b10));
        step("addi_wb", 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd5, F_RWR, 2'b00));
        do_reset("reset_after_addi");

        // Reset in the middle of a load abandons it; FETCH resumes afterwards
        fetch("abort_fetch");
        decode("abort_decode", 11'h7C2);
        step("abort_addr", 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd3, F_ASR, 2'b00));
        step("abort_mem_wait", 1'b0, 1'b0, 1'b0, 1'b0, ex(3'd4, F_MRD, 2'b00));
        do_reset("abort_reset");
        fetch("resume_fetch");
        decode("resume_decode", 11'h658);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
